// File: rtl/apu_pkg.sv
// Shared APU definitions: channel 4 register selects and readback constants.
package apu_pkg;

    typedef enum logic [1:0] {
        CH4_NR41 = 2'd0,
        CH4_NR42 = 2'd1,
        CH4_NR43 = 2'd2,
        CH4_NR44 = 2'd3
    } ch4_reg_e;

    localparam logic [5:0] CH4_LEN_MAX  = 6'd63;
    localparam logic [7:0] NR44_RD_MASK = 8'hBF;

endpackage

// File: rtl/ch4_reg_len_if.sv
// CPU register bus between the APU decoder and the channel 4 register file.
interface ch4_reg_len_if;

    logic       reg_cs;
    logic [1:0] reg_sel;
    logic       cpu_wr;
    logic       cpu_rd;
    logic [7:0] cpu_din;
    logic [7:0] cpu_dout;
    logic       cpu_doe;

    modport master (
        output reg_cs, reg_sel, cpu_wr, cpu_rd, cpu_din,
        input  cpu_dout, cpu_doe
    );

    modport slave (
        input  reg_cs, reg_sel, cpu_wr, cpu_rd, cpu_din,
        output cpu_dout, cpu_doe
    );

endinterface

// File: rtl/ch4_len_ctr.sv
// Channel 4 length counter: counts len ticks up to wrap, then flags expiry in fugo_q.
module ch4_len_ctr
    import apu_pkg::*;
#(
    parameter int unsigned LEN_W = 6
) (
    input  logic             clk,
    input  logic             napu_reset,
    input  logic             clr,
    input  logic             load,
    input  logic [LEN_W-1:0] load_val,
    input  logic             trig,
    input  logic             tick,
    output logic             fugo_q
);

    logic [LEN_W-1:0] cnt_q;

    // Load beats trigger-reload beats tick; a tick colliding with a load is dropped.
    always_ff @(posedge clk) begin
        if (!napu_reset || clr) begin
            cnt_q  <= '0;
            fugo_q <= 1'b0;
        end else if (load) begin
            cnt_q  <= load_val;
            fugo_q <= 1'b0;
        end else if (trig && fugo_q) begin
            cnt_q  <= '0;
            fugo_q <= 1'b0;
        end else if (tick && !fugo_q) begin
            if (cnt_q == LEN_W'(CH4_LEN_MAX)) begin
                cnt_q  <= '0;
                fugo_q <= 1'b1;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ch4_reg_len.sv
// NR41-NR44 register file, trigger latch and length counter for noise channel 4.
// CH4_LEN_WRITE_WHILE_OFF_EN keeps the length counter live and writable while the APU is off.
module ch4_reg_len
    import apu_pkg::*;
#(
    parameter int unsigned LEN_W   = 6,
    parameter logic [7:0]  RD_FILL = 8'hFF
) (
    input  logic         clk,
    input  logic         napu_reset,
    input  logic         apu_en,
    ch4_reg_len_if.slave bus,
    input  logic         len_tick,
    input  logic         rst_ff23_d7,
    output logic [7:0]   ff21,
    output logic [7:0]   ff22,
    output logic         ff23_d6,
    output logic         ff23_d7,
    output logic         fugo_q
);

    ch4_reg_e sel;
    logic     wr, wr20, wr21, wr22, wr23;
    logic     len_load, len_clr;

    assign sel  = ch4_reg_e'(bus.reg_sel);
    assign wr   = bus.cpu_wr && bus.reg_cs;
    assign wr20 = wr && (sel == CH4_NR41);
    assign wr21 = wr && (sel == CH4_NR42) && apu_en;
    assign wr22 = wr && (sel == CH4_NR43) && apu_en;
    assign wr23 = wr && (sel == CH4_NR44) && apu_en;

`ifdef CH4_LEN_WRITE_WHILE_OFF_EN
    assign len_load = wr20;
    assign len_clr  = 1'b0;
`else
    assign len_load = wr20 && apu_en;
    assign len_clr  = !apu_en;
`endif

    always_ff @(posedge clk) begin
        if (!napu_reset || !apu_en) begin
            ff21    <= 8'h00;
            ff22    <= 8'h00;
            ff23_d6 <= 1'b0;
            ff23_d7 <= 1'b0;
        end else begin
            if (wr21) ff21 <= bus.cpu_din;
            if (wr22) ff22 <= bus.cpu_din;
            if (wr23) ff23_d6 <= bus.cpu_din[6];
            // A new trigger outranks the channel's acknowledge on the same edge.
            if (wr23 && bus.cpu_din[7]) begin
                ff23_d7 <= 1'b1;
            end else if (rst_ff23_d7) begin
                ff23_d7 <= 1'b0;
            end
        end
    end

    // Tick gating uses the registered enable, i.e. the value before a same-edge FF23 write.
    ch4_len_ctr #(
        .LEN_W (LEN_W)
    ) u_len_ctr (
        .clk        (clk),
        .napu_reset (napu_reset),
        .clr        (len_clr),
        .load       (len_load),
        .load_val   (bus.cpu_din[LEN_W-1:0]),
        .trig       (wr23 && bus.cpu_din[7]),
        .tick       (len_tick && ff23_d6),
        .fugo_q     (fugo_q)
    );

    assign bus.cpu_doe = bus.cpu_rd && bus.reg_cs;

    always_comb begin
        bus.cpu_dout = 8'h00;
        if (bus.cpu_doe) begin
            case (sel)
                CH4_NR41: bus.cpu_dout = RD_FILL;
                CH4_NR42: bus.cpu_dout = ff21;
                CH4_NR43: bus.cpu_dout = ff22;
                CH4_NR44: bus.cpu_dout = NR44_RD_MASK | {1'b0, ff23_d6, 6'b000000};
                default:  bus.cpu_dout = 8'h00;
            endcase
        end
    end

endmodule
